// File: rtl/q31_mux_sequencer_pkg.sv
// Shared definitions for the Q31 N-way selector and its sequencer.
package q31_mux_sequencer_pkg;

    localparam int unsigned Q31_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/q31_mux_sequencer_nway_select.sv
// Combinational N-way word selector; out-of-range indices clamp to the last channel.
module q31_nway_select
    import q31_mux_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = Q31_W,
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned SEL_W  = 3
) (
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        word_c,
    output logic [SEL_W-1:0]        ch_c
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

    always_comb begin
        ch_c   = (sel > LAST_CH) ? LAST_CH : sel;
        word_c = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (ch_c == SEL_W'(k)) begin
                word_c = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/q31_mux_sequencer.sv
// N-way Q31 selector with registered valid/ready output and an auto-scan mode.
module q31_mux_sequencer
    import q31_mux_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = Q31_W,
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned SEL_W  = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    req,
    input  logic                    scan,
    input  logic                    abort,
    output logic [WIDTH-1:0]        out,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic              slot_free_c;
    logic              capture_c;
    logic              cap_last_c;
    logic [SEL_W-1:0]  cap_idx_c;
    logic [WIDTH-1:0]  sel_word_c;
    logic [SEL_W-1:0]  sel_ch_c;

    assign slot_free_c = !out_valid_q || out_ready;

    q31_nway_select #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_select (
        .in_bus (in_bus),
        .sel    (cap_idx_c),
        .word_c (sel_word_c),
        .ch_c   (sel_ch_c)
    );

    // State and scan counter register; a reset discards any scan in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: the counter only advances on beats that actually capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (scan) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (slot_free_c) begin
                    if (cnt_q == LAST_CH) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + SEL_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture decode: scan beats select the counter, single requests select sel.
    always_comb begin
        capture_c  = 1'b0;
        cap_last_c = 1'b0;
        cap_idx_c  = sel;
        unique case (state_q)
            ST_IDLE: begin
                capture_c  = !scan && req && slot_free_c;
                cap_last_c = 1'b1;
            end
            ST_SCAN: begin
                cap_idx_c  = cnt_q;
                capture_c  = !abort && slot_free_c;
                cap_last_c = (cnt_q == LAST_CH);
            end
            default: begin
                capture_c = 1'b0;
            end
        endcase
    end

    // Output slot: load on capture, drain when free, otherwise hold.
    always_comb begin
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (capture_c) begin
            out_d       = sel_word_c;
            out_ch_d    = sel_ch_c;
            out_last_d  = cap_last_c;
            out_valid_d = 1'b1;
        end else if (slot_free_c) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_SCAN);

endmodule

// File: tb/tb_q31_mux_sequencer.sv
// Scoreboard bench for q31_mux_sequencer: expected words queued at stimulus, popped on handshake.
module tb_q31_mux_sequencer;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 5;
    localparam int unsigned SEL_W  = 3;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] ch;
        logic             last;
    } exp_t;

    logic                    clock;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    req;
    logic                    scan;
    logic                    abort;
    logic [WIDTH-1:0]        out;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;
    logic                    busy;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    q31_mux_sequencer #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_bus    (in_bus),
        .sel       (sel),
        .req       (req),
        .scan      (scan),
        .abort     (abort),
        .out       (out),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] chan_word(input int k);
        return WIDTH'(32'h1000_0000 * (k + 1));
    endfunction

    function automatic exp_t mk(input int k, input logic last);
        exp_t e;
        e.d    = chan_word(k);
        e.ch   = SEL_W'(k);
        e.last = last;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: pops on every accepted beat and checks stall stability.
    initial begin
        logic             hold_chk;
        logic [WIDTH-1:0] hold_out;
        logic [SEL_W-1:0] hold_ch;
        logic             hold_last;
        exp_t             e;
        hold_chk = 1'b0;
        hold_out = '0;
        hold_ch  = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                if (hold_chk) begin
                    checks++;
                    if (out_valid !== 1'b1 || out !== hold_out || out_ch !== hold_ch || out_last !== hold_last) begin
                        failures++;
                        $display("FAIL stall_hold: got v=%b out=%h ch=%0d last=%b, need v=1 out=%h ch=%0d last=%b",
                                 out_valid, out, out_ch, out_last, hold_out, hold_ch, hold_last);
                    end
                end
                hold_chk  = (out_valid === 1'b1) && (out_ready === 1'b0);
                hold_out  = out;
                hold_ch   = out_ch;
                hold_last = out_last;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat: got out=%h ch=%0d last=%b, need no beat", out, out_ch, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (out !== e.d || out_ch !== e.ch || out_last !== e.last) begin
                            failures++;
                            $display("FAIL beat: got out=%h ch=%0d last=%b, need out=%h ch=%0d last=%b",
                                     out, out_ch, out_last, e.d, e.ch, e.last);
                        end
                    end
                end
            end else begin
                hold_chk = 1'b0;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (out !== '0 || out_ch !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: got out=%h ch=%0d v=%b last=%b busy=%b, need all 0", out, out_ch, out_valid, out_last, busy);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_select();
        out_ready = 1'b1;
        sel = 3'd2;
        req = 1'b1;
        exp_q.push_back(mk(2, 1'b1));
        tick();
        req = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h3000_0000 || out_ch !== 3'd2 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL single_select: got v=%b out=%h ch=%0d last=%b, need v=1 out=30000000 ch=2 last=1",
                     out_valid, out, out_ch, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: got v=%b, need 0", out_valid);
        end
    endtask

    task automatic test_clamp();
        sel = 3'd7;
        req = 1'b1;
        exp_q.push_back(mk(NUM_IN - 1, 1'b1));
        tick();
        req = 1'b0;
        checks++;
        if (out !== 32'h5000_0000 || out_ch !== 3'd4) begin
            failures++;
            $display("FAIL clamp: got out=%h ch=%0d, need out=50000000 ch=4", out, out_ch);
        end
        tick();
    endtask

    task automatic test_full_scan();
        out_ready = 1'b1;
        for (int k = 0; k < NUM_IN; k++) exp_q.push_back(mk(k, k == NUM_IN - 1));
        scan = 1'b1;
        tick();
        scan = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL scan_start: got busy=%b v=%b, need busy=1 v=0", busy, out_valid);
        end
        for (int k = 0; k < NUM_IN; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== SEL_W'(k) || busy !== (k != NUM_IN - 1)) begin
                failures++;
                $display("FAIL scan_beat%0d: got v=%b ch=%0d busy=%b, need v=1 ch=%0d busy=%b",
                         k, out_valid, out_ch, busy, k, (k != NUM_IN - 1));
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL scan_end: got v=%b pending=%0d, need v=0 pending=0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < NUM_IN; k++) exp_q.push_back(mk(k, k == NUM_IN - 1));
        out_ready = 1'b1;
        scan = 1'b1;
        tick();
        scan = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            out_ready = pat[i % 4];
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_timeout: got pending=%0d, need 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_end: got busy=%b v=%b, need 0 0", busy, out_valid);
        end
    endtask

    task automatic test_abort_priority();
        out_ready = 1'b1;
        exp_q.push_back(mk(0, 1'b0));
        exp_q.push_back(mk(1, 1'b0));
        scan = 1'b1;
        tick();
        scan = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        out_ready = 1'b0;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || out_ch !== 3'd1 || out_last !== 1'b0 || out !== 32'h2000_0000) begin
            failures++;
            $display("FAIL abort: got busy=%b v=%b ch=%0d last=%b out=%h, need busy=0 v=1 ch=1 last=0 out=20000000",
                     busy, out_valid, out_ch, out_last, out);
        end
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_drain: got v=%b busy=%b, need 0 0", out_valid, busy);
        end
        for (int k = 0; k < NUM_IN; k++) exp_q.push_back(mk(k, k == NUM_IN - 1));
        scan = 1'b1;
        req = 1'b1;
        sel = 3'd3;
        tick();
        scan = 1'b0;
        req = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL priority: got busy=%b v=%b, need busy=1 v=0", busy, out_valid);
        end
        for (int k = 0; k < NUM_IN + 1; k++) tick();
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL priority_end: got pending=%0d busy=%b, need 0 0", exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_scan();
        out_ready = 1'b1;
        exp_q.push_back(mk(0, 1'b0));
        exp_q.push_back(mk(1, 1'b0));
        scan = 1'b1;
        tick();
        scan = 1'b0;
        tick();
        tick();
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (out !== '0 || out_ch !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_scan: got out=%h ch=%0d v=%b last=%b busy=%b, need all 0",
                     out, out_ch, out_valid, out_last, busy);
        end
        tick();
        reset = 1'b1;
        tick();
        sel = 3'd1;
        req = 1'b1;
        exp_q.push_back(mk(1, 1'b1));
        tick();
        req = 1'b0;
        checks++;
        if (out !== 32'h2000_0000 || out_ch !== 3'd1 || out_valid !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_req: got out=%h ch=%0d v=%b busy=%b, need out=20000000 ch=1 v=1 busy=0",
                     out, out_ch, out_valid, busy);
        end
        tick();
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_drain: got pending=%0d v=%b, need 0 0", exp_q.size(), out_valid);
            exp_q.delete();
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        sel       = '0;
        req       = 1'b0;
        scan      = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < NUM_IN; k++) in_bus[k*WIDTH +: WIDTH] = chan_word(k);
        test_reset();
        test_single_select();
        test_clamp();
        test_full_scan();
        test_backpressure();
        test_abort_priority();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
